// File: rtl/fuzzy_sweep_capture.sv
// Grid-sweep stimulus generator and result logger for the Fuzzy_1 controller.
// Walks a 2-D input grid, samples the controller output after a settle time, and queues records.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start after reset
// APPLY   | drive the current grid point onto Entrada_01/Entrada_02
// SETTLE  | hold inputs while the settle down-counter runs to zero
// CAPTURE | push {e1,e2,y} into the result FIFO; stall while it is full
// DONE    | sweep complete, last point held, waiting for a new start

module fuzzy_sweep_capture #(
  parameter int STEP       = 16,
  parameter int SETTLE     = 28,
  parameter int MIN_IN     = 1,
  parameter int MAX_IN     = 254,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_0,
  input  logic        Srst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  Entrada_01,
  output logic [7:0]  Entrada_02,
  input  logic [7:0]  saida_defuzzy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [23:0] res_data,
  output logic [8:0]  res_count
);

  localparam int N    = 256 / STEP + 1;
  localparam int IW   = $clog2(N);
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [8:0]    MAX_CNT  = 9'(N * N);
  localparam logic [SW-1:0] SETTLE_TC = SW'(SETTLE - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE_S = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [IW-1:0] idx_i;
  logic [IW-1:0] idx_j;
  logic [SW-1:0] settle_cnt;

  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          last_point;

  // Grid value: raw = k*STEP on 9 bits so 256 is representable before clamping.
  function automatic logic [7:0] grid_val(input logic [IW-1:0] k);
    logic [8:0] raw;
    raw = 9'(k) * 9'(STEP);
    if (raw < 9'(MIN_IN))
      return 8'(MIN_IN);
    else if (raw > 9'(MAX_IN))
      return 8'(MAX_IN);
    else
      return raw[7:0];
  endfunction

  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign res_valid  = (fifo_cnt != '0);
  assign push       = (state == CAPTURE) && !fifo_full;
  assign pop        = res_valid && res_ready;
  assign last_point = (idx_i == LAST_IDX) && (idx_j == LAST_IDX);
  assign res_data   = fifo_mem[rd_ptr];

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_count  <= '0;
      Entrada_01 <= 8'd1;
      Entrada_02 <= 8'd1;
      idx_i      <= '0;
      idx_j      <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx_i     <= '0;
            idx_j     <= '0;
            res_count <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= APPLY;
          end
        end
        APPLY: begin
          Entrada_01 <= grid_val(idx_i);
          Entrada_02 <= grid_val(idx_j);
          settle_cnt <= SETTLE_TC;
          state      <= SETTLE_S;
        end
        SETTLE_S: begin
          if (settle_cnt != '0)
            settle_cnt <= settle_cnt - 1'b1;
          else
            state <= CAPTURE;
        end
        CAPTURE: begin
          // A full FIFO stalls here with the inputs still applied; nothing is dropped.
          if (!fifo_full) begin
            if (res_count != MAX_CNT)
              res_count <= res_count + 1'b1;
            if (last_point) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              if (idx_j == LAST_IDX) begin
                idx_j <= '0;
                idx_i <= idx_i + 1'b1;
              end else begin
                idx_j <= idx_j + 1'b1;
              end
              state <= APPLY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage has no reset so stale records survive a new start, as the consumer expects.
  always_ff @(posedge clk_0) begin
    if (push)
      fifo_mem[wr_ptr] <= {Entrada_01, Entrada_02, saida_defuzzy};
  end

endmodule

// File: tb/tb_fuzzy_sweep_capture.sv
// Directed bench for fuzzy_sweep_capture: timing, backpressure, reset and restart scenarios
// against a y=(e1+e2)>>1 controller stand-in with an override for timing probes.

module tb_fuzzy_sweep_capture;

  logic        clk_0 = 1'b0;
  logic        Srst = 1'b1;
  logic        start = 1'b0;
  logic        res_ready = 1'b0;
  logic        busy, done, res_valid;
  logic [7:0]  Entrada_01, Entrada_02, saida_defuzzy;
  logic [23:0] res_data;
  logic [8:0]  res_count;

  logic        y_ovr_en = 1'b0;
  logic [7:0]  y_ovr = 8'd0;
  logic [8:0]  y_sum;

  int vectors = 0;
  int miscompares = 0;
  int rec_idx = 0;

  assign y_sum = {1'b0, Entrada_01} + {1'b0, Entrada_02};
  assign saida_defuzzy = y_ovr_en ? y_ovr : y_sum[8:1];

  always #5 clk_0 = ~clk_0;

  fuzzy_sweep_capture dut (
    .clk_0         (clk_0),
    .Srst          (Srst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .Entrada_01    (Entrada_01),
    .Entrada_02    (Entrada_02),
    .saida_defuzzy (saida_defuzzy),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_count     (res_count)
  );

  // Default grid: 1,16,32,...,240,254.
  function automatic logic [7:0] gv(input int k);
    if (k == 0)  return 8'd1;
    if (k == 16) return 8'd254;
    return 8'(k * 16);
  endfunction

  function automatic logic [23:0] exp_rec(input int r);
    logic [7:0] a, b;
    logic [8:0] s;
    a = gv(r / 17);
    b = gv(r % 17);
    s = {1'b0, a} + {1'b0, b};
    return {a, b, s[8:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; any pop that happens on the coming posedge is scored first.
  task automatic tick();
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      check("record", 32'(res_data), 32'(exp_rec(rec_idx % 289)));
      rec_idx++;
    end
    @(posedge clk_0);
    @(negedge clk_0);
  endtask

  task automatic wait_count(input int target, input int budget, input string tag);
    int n = 0;
    while (res_count !== 9'(target) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(res_count), 32'(target));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (res_valid === 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    @(negedge clk_0);
    tick();
    tick();
    Srst = 1'b0;
    tick();
    tick();
    // Reset state, no start
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_e1",    32'(Entrada_01), 32'd1);
    check("rst_e2",    32'(Entrada_02), 32'd1);
    check("rst_count", 32'(res_count), 32'd0);

    // First-point sample timing: push lands 29 edges after the APPLY edge
    y_ovr_en = 1'b1;
    y_ovr    = 8'h33;
    pulse_start();
    check("t3_busy", 32'(busy), 32'd1);
    tick();
    repeat (28) tick();
    check("t3_no_early_push", 32'(res_valid), 32'd0);
    y_ovr = 8'h55;
    tick();
    check("t3_push_at_29", 32'(res_valid), 32'd1);
    check("t3_captured", 32'(res_data), 32'h010155);
    y_ovr = 8'h77;
    tick();
    check("t3_late_change_ignored", 32'(res_data), 32'h010155);
    check("t3_count1", 32'(res_count), 32'd1);
    check("t3_next_point", 32'(Entrada_02), 32'd16);
    Srst = 1'b1;
    tick();
    Srst = 1'b0;
    y_ovr_en = 1'b0;
    rec_idx = 0;
    tick();
    check("t3_fifo_cleared", 32'(res_valid), 32'd0);

    // Backpressure: 8 pushes then stall in CAPTURE on point 8
    res_ready = 1'b0;
    pulse_start();
    wait_count(8, 400, "t4_fill_8");
    repeat (100) tick();
    check("t4_stall_count", 32'(res_count), 32'd8);
    check("t4_stall_busy",  32'(busy), 32'd1);
    check("t4_stall_e1",    32'(Entrada_01), 32'd1);
    check("t4_stall_e2",    32'(Entrada_02), 32'd128);
    check("t4_stall_head",  32'(res_data), 32'h010101);
    res_ready = 1'b1;
    wait_done(12000, "t4_done");
    drain();
    check("t4_records", 32'(rec_idx), 32'd289);
    check("t4_count",   32'(res_count), 32'd289);
    check("t4_empty",   32'(res_valid), 32'd0);
    check("t4_busy",    32'(busy), 32'd0);
    check("t4_last_e1", 32'(Entrada_01), 32'd254);
    check("t4_last_e2", 32'(Entrada_02), 32'd254);

    // Reset during SETTLE of point 100 (i=5, j=15)
    Srst = 1'b1;
    tick();
    Srst = 1'b0;
    rec_idx = 0;
    tick();
    pulse_start();
    wait_count(100, 4000, "t5_reach_100");
    repeat (10) tick();
    check("t5_mid_busy", 32'(busy), 32'd1);
    check("t5_mid_e1",   32'(Entrada_01), 32'd80);
    check("t5_mid_e2",   32'(Entrada_02), 32'd240);
    Srst = 1'b1;
    #1;
    check("t5_rst_busy",  32'(busy), 32'd0);
    check("t5_rst_done",  32'(done), 32'd0);
    check("t5_rst_valid", 32'(res_valid), 32'd0);
    check("t5_rst_e1",    32'(Entrada_01), 32'd1);
    check("t5_rst_e2",    32'(Entrada_02), 32'd1);
    check("t5_rst_count", 32'(res_count), 32'd0);
    @(negedge clk_0);
    Srst = 1'b0;
    rec_idx = 0;
    tick();
    pulse_start();
    check("t5_restart_count0", 32'(res_count), 32'd0);
    check("t5_restart_busy",   32'(busy), 32'd1);

    // Starts while busy are ignored (first lands in APPLY)
    pulse_start();
    repeat (3) begin
      repeat (700) tick();
      pulse_start();
    end
    wait_done(12000, "t6_done");
    drain();
    check("t6_records", 32'(rec_idx), 32'd289);
    check("t6_count",   32'(res_count), 32'd289);

    // Start from DONE: done drops next cycle and a full sweep reruns
    rec_idx = 0;
    pulse_start();
    check("t6_done_drop",   32'(done), 32'd0);
    check("t6_rerun_busy",  32'(busy), 32'd1);
    check("t6_rerun_count", 32'(res_count), 32'd0);
    wait_done(12000, "t6_rerun_done");
    drain();
    check("t6_rerun_records", 32'(rec_idx), 32'd289);
    check("t6_rerun_count_end", 32'(res_count), 32'd289);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
